// File: rtl/calc_pkg.sv
// Shared types for the calculator command issuer: ALU opcodes, the command word and the issuer FSM states.
package calc_pkg;

  typedef enum logic [2:0] {
    OP_INIT  = 3'b000,
    OP_LOADK = 3'b001,
    OP_MOVE  = 3'b010,
    OP_COPY  = 3'b011,
    OP_ADD   = 3'b100,
    OP_SUB   = 3'b101,
    OP_MUL   = 3'b110,
    OP_POW2  = 3'b111
  } op_e;

  typedef struct packed {
    logic [2:0] op;
    logic [1:0] k;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } iss_state_e;

endpackage

// File: rtl/calc_cmd_fifo.sv
// Synchronous FIFO with full/empty flags; DEPTH must be a power of two so the pointers wrap for free.
module calc_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  // Push is gated by the registered full flag only, so a pop never frees a slot in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/calc_op_issuer.sv
// Issues queued calculator commands to the ALU one at a time and returns one captured result per command.
// Optional CALC_ISSUE_COUNT_EN adds an 8-bit wrapping count of issued commands.
module calc_op_issuer
  import calc_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int DATA_W        = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_data,
  output logic              perform,
  output logic [2:0]        op,
  output logic [1:0]        k,
  input  logic [DATA_W-1:0] alu_r0,
  input  logic [DATA_W-1:0] alu_r1,
  input  logic [DATA_W-1:0] alu_r2,
  input  logic [DATA_W-1:0] alu_r3,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              busy
`ifdef CALC_ISSUE_COUNT_EN
  ,
  output logic [7:0]        issue_count
`endif
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  iss_state_e        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [1:0]        k_q, k_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [DATA_W-1:0] sel_res;
  logic [4:0]        head_w;
  cmd_t              head;
  logic              fifo_full, fifo_empty, pop;

  calc_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid),
    .data_i  (cmd_data),
    .pop_i   (pop),
    .data_o  (head_w),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head = cmd_t'(head_w);

  // COPY reports its destination register; every other op leaves its result in r0.
  always_comb begin
    sel_res = alu_r0;
    if (op_q == OP_COPY) begin
      case (k_q)
        2'd0:    sel_res = alu_r0;
        2'd1:    sel_res = alu_r1;
        2'd2:    sel_res = alu_r2;
        default: sel_res = alu_r3;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          op_d    = head.op;
          k_d     = head.k;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          res_d   = sel_res;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= 3'b000;
      k_q     <= 2'b00;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // Decoded from the state register so a reset edge drops them immediately.
  assign perform   = (state_q == ST_ISSUE);
  assign res_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign cmd_ready = !fifo_full;
  assign op        = op_q;
  assign k         = k_q;
  assign res_data  = res_q;

`ifdef CALC_ISSUE_COUNT_EN
  logic [7:0] issue_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                       issue_cnt_q <= 8'd0;
    else if (state_q == ST_ISSUE)  issue_cnt_q <= issue_cnt_q + 8'd1;
  end

  assign issue_count = issue_cnt_q;
`endif

endmodule

// File: tb/tb_calc_op_issuer.sv
// Randomized + directed bench for calc_op_issuer against a queue-based command/result model.
module tb_calc_op_issuer;
  import calc_pkg::*;

  localparam int DEPTH = 4;
`ifdef CALC_ISSUE_COUNT_EN
  localparam int SETTLE = 3;
`else
  localparam int SETTLE = 1;
`endif

  logic       clk, rst;
  logic       cmd_valid, cmd_ready;
  logic [4:0] cmd_data;
  logic       perform;
  logic [2:0] op;
  logic [1:0] k;
  logic [4:0] alu_r0, alu_r1, alu_r2, alu_r3;
  logic       res_valid, res_ready;
  logic [4:0] res_data;
  logic       busy;
`ifdef CALC_ISSUE_COUNT_EN
  logic [7:0] issue_count;
`endif

  calc_op_issuer #(.FIFO_DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE), .DATA_W(5)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .perform(perform), .op(op), .k(k),
    .alu_r0(alu_r0), .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_r3(alu_r3),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
`ifdef CALC_ISSUE_COUNT_EN
    , .issue_count(issue_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference ALU register file; the monitor owns it so it only changes away from capture windows.
  logic [4:0] alu_v [4];
  logic [4:0] dir_alu [4];
  bit         rand_alu = 1'b0;
  assign alu_r0 = alu_v[0];
  assign alu_r1 = alu_v[1];
  assign alu_r2 = alu_v[2];
  assign alu_r3 = alu_v[3];

  function automatic logic [4:0] model(input cmd_t c);
    return (c.op == OP_COPY) ? alu_v[c.k] : alu_v[0];
  endfunction

  cmd_t push_q[$];
  cmd_t infl_q[$];
  cmd_t mc;
  int   nperf = 0, nres = 0, iss_cnt = 0;

  always @(negedge clk) begin
    if (!rand_alu) for (int i = 0; i < 4; i++) alu_v[i] = dir_alu[i];
    if (rst) begin
      push_q.delete();
      infl_q.delete();
      iss_cnt = 0;
    end else begin
      if (perform) begin
        if (push_q.size() == 0) chk("perform_without_cmd", 1, 0);
        else begin
          mc = push_q.pop_front();
          chk("issue_opk", {27'd0, op, k}, {27'd0, mc});
          infl_q.push_back(mc);
        end
        nperf++;
        iss_cnt++;
        if (rand_alu) for (int i = 0; i < 4; i++) alu_v[i] = 5'($urandom);
      end
      if (res_valid && res_ready) begin
        if (infl_q.size() == 0) chk("result_without_cmd", 1, 0);
        else begin
          mc = infl_q.pop_front();
          chk("res_data", {27'd0, res_data}, {27'd0, model(mc)});
        end
        nres++;
      end
      if (cmd_valid && cmd_ready) push_q.push_back(cmd_t'(cmd_data));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!res_valid && n < max) begin
      tick();
      n++;
    end
    if (!res_valid) chk("timeout_res_valid", 0, 1);
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    chk("drain_idle", {31'd0, busy}, 0);
  endtask

  int   n, bperf, bres;
  logic [4:0] h_data;
  logic [4:0] h_opk;
  cmd_t fc [5];

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin dir_alu[i] = '0; alu_v[i] = '0; end
    tick(); tick();
    rst = 1'b0;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("rst_perform",   {31'd0, perform}, 0);
    chk("rst_res_valid", {31'd0, res_valid}, 0);
    chk("rst_res_data",  {27'd0, res_data}, 0);
    chk("rst_busy",      {31'd0, busy}, 0);
    chk("rst_opk",       {27'd0, op, k}, 0);
`ifdef CALC_ISSUE_COUNT_EN
    chk("rst_issue_count", {24'd0, issue_count}, 0);
`endif

    // Single ADD: r0 holds 3+4 from the ALU.
    dir_alu[0] = 5'd7; dir_alu[1] = 5'd3; dir_alu[2] = 5'd4; dir_alu[3] = 5'd0;
    tick();
    cmd_valid = 1'b1; cmd_data = {OP_ADD, 2'b01};
    tick();
    cmd_valid = 1'b0;
    chk("t1_perform_n1", {31'd0, perform}, 0);
    chk("t1_busy_n1", {31'd0, busy}, 1);
    tick();
    chk("t1_perform_n2", {31'd0, perform}, 1);
    chk("t1_opk_n2", {27'd0, op, k}, {27'd0, OP_ADD, 2'b01});
    wait_valid(20, n);
    chk("t1_latency", n, SETTLE + 1);
    chk("t1_res_data", {27'd0, res_data}, 7);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("t1_valid_drop", {31'd0, res_valid}, 0);
    chk("t1_busy_end", {31'd0, busy}, 0);

    // COPY selects the destination register.
    dir_alu[0] = 5'd1; dir_alu[1] = 5'd2; dir_alu[2] = 5'd9; dir_alu[3] = 5'd3;
    tick();
    cmd_valid = 1'b1; cmd_data = {OP_COPY, 2'b10};
    tick();
    cmd_valid = 1'b0;
    wait_valid(20, n);
    chk("t2_copy_data", {27'd0, res_data}, 9);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Fill the FIFO behind a stalled result, then hold and drain.
    fc[0] = {OP_COPY, 2'd1}; fc[1] = {OP_COPY, 2'd2}; fc[2] = {OP_ADD, 2'd0};
    fc[3] = {OP_COPY, 2'd3}; fc[4] = {OP_COPY, 2'd0};
    bperf = nperf; bres = nres;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_data = fc[i];
      chk("t3_ready_offer", {31'd0, cmd_ready}, 1);
      tick();
    end
    cmd_data = 5'h1F;
    chk("t3_ready_full", {31'd0, cmd_ready}, 0);
    tick();
    cmd_valid = 1'b0;
    chk("t3_still_full", {31'd0, cmd_ready}, 0);
    wait_valid(20, n);
    h_data = res_data; h_opk = {op, k};
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_hold_valid", {31'd0, res_valid}, 1);
      chk("t3_hold_data", {27'd0, res_data}, {27'd0, h_data});
      chk("t3_hold_opk", {27'd0, op, k}, {27'd0, h_opk});
      chk("t3_hold_noperf", {31'd0, perform}, 0);
    end
    res_ready = 1'b1;
    wait_idle(100);
    tick();
    res_ready = 1'b0;
    chk("t3_results", nres - bres, 5);
    chk("t3_performs", nperf - bperf, 5);

    // Reset while the first of three commands sits in WAIT.
    res_ready = 1'b1;
    bperf = nperf; bres = nres;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_data = {OP_SUB, 2'(i)};
      tick();
    end
    chk("t4_busy_pre", {31'd0, busy}, 1);
    chk("t4_in_wait", {31'd0, perform}, 0);
    rst = 1'b1; cmd_valid = 1'b0;
    tick();
    chk("t4_perform", {31'd0, perform}, 0);
    chk("t4_res_valid", {31'd0, res_valid}, 0);
    chk("t4_res_data", {27'd0, res_data}, 0);
    chk("t4_opk", {27'd0, op, k}, 0);
    chk("t4_busy", {31'd0, busy}, 0);
    chk("t4_cmd_ready", {31'd0, cmd_ready}, 1);
    rst = 1'b0;
    repeat (15) tick();
    chk("t4_no_results", nres - bres, 0);
    chk("t4_one_perform", nperf - bperf, 1);
    chk("t4_busy_after", {31'd0, busy}, 0);

    // Randomized traffic with a churning ALU.
    rand_alu = 1'b1;
    bres = nres;
    repeat (600) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_data  = 5'($urandom);
      res_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    wait_idle(300);
    tick();
    chk("rnd_pushq_empty", push_q.size(), 0);
    chk("rnd_inflq_empty", infl_q.size(), 0);
    chk("rnd_progress", {31'd0, (nres - bres) > 20}, 1);

`ifdef CALC_ISSUE_COUNT_EN
    chk("cnt_match", {24'd0, issue_count}, iss_cnt & 255);
    n = 0;
    bperf = 0;
    while (bperf < 260 && n < 5000) begin
      cmd_valid = 1'b1;
      cmd_data  = 5'($urandom);
      if (cmd_ready) bperf++;
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    wait_idle(300);
    tick();
    chk("cnt_wrapped", {31'd0, iss_cnt > 255}, 1);
    chk("cnt_wrap_match", {24'd0, issue_count}, iss_cnt & 255);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_op_issuer.md
Name: calc_op_issuer

Overview:
- Command-side initiator for the calculator register-switch/ALU block.
- Buffers 5-bit calculator commands ({OP[2:0], K[1:0]}) from the keypad/control front end in a small FIFO.
- Drives one command at a time onto the ALU's Perform/OP/K inputs, waits a fixed settle time, captures the ALU register outputs, and returns one result word per command over a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 4: command FIFO entries; power of two, minimum 2.
- SETTLE_CYCLES, 1: cycles between the Perform pulse and result capture; minimum 1.
- DATA_W, 5: ALU register width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command FIFO can accept.
- cmd_data  in  5  {op[2:0], k[1:0]}.
- perform  out  1  to ALU Perform; one-cycle pulse per command.
- op  out  3  to ALU OP.
- k  out  2  to ALU K.
- alu_r0, alu_r1, alu_r2, alu_r3  in  DATA_W each  ALU register outputs.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer accepts.
- res_data  out  DATA_W  captured result.
- busy  out  1  FSM not IDLE or FIFO non-empty.

Behaviour:
- Reset (synchronous, active-high):
  - FIFO emptied; FSM to IDLE.
  - perform=0, op=3'b000, k=2'b00, res_valid=0, res_data=0, busy=0.
  - cmd_ready=1 from the first cycle after reset.
  - A reset mid-operation abandons the in-flight command and all queued commands. perform drops on that same edge.
- FIFO:
  - Push when cmd_valid && cmd_ready; cmd_ready = !full.
  - No pass-through: a push while full is not possible, even if a pop occurs in the same cycle.
  - Simultaneous push and pop is legal when not full; the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head, register it into op/k, go to ISSUE.
  - ISSUE: perform=1 for exactly one cycle; go to WAIT; load the settle counter with SETTLE_CYCLES-1.
  - WAIT: count down. At zero, capture the result into res_data and go to DONE.
  - DONE: res_valid=1. On res_ready, go to IDLE and drop res_valid.
  - A queued command is popped in IDLE no earlier than the cycle after DONE exits. There is no back-to-back overlap.
- op/k stability: op/k change only on the IDLE->ISSUE edge and stay stable through WAIT and DONE, because the ALU is level-sensitive on OP.
- Result selection:
  - OP=3'b011: res_data = alu_r[k] (the copy destination).
  - All other OP values: res_data = alu_r0.
- Latency: a command accepted in cycle N into an empty FIFO, with the FSM in IDLE, produces:
  - pop in N+1;
  - perform in N+2;
  - res_valid in N+3+SETTLE_CYCLES.
- res_data holds stable while res_valid=1 && !res_ready.
- busy = (state != IDLE) || !empty.

Optional Feature:
- Macro: CALC_ISSUE_COUNT_EN.
- Defined:
  - Adds output issue_count[7:0].
  - Increments by 1 on every ISSUE cycle and wraps 255->0.
  - Reset to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package calc_pkg holds:
  - OP encodings (OP_INIT=3'b000, OP_LOADK, OP_MOVE, OP_COPY, OP_ADD, OP_SUB, OP_MUL, OP_POW2);
  - the cmd_t struct {op, k};
  - the issuer FSM state enum.
- One sub-module: calc_cmd_fifo (parameterised synchronous FIFO with full/empty). The FSM, settle counter and result mux stay in the top.

Test Plan:
- Reset then single command:
  - Stimulus: ALU model with a=3, b=4; push {3'b100, 2'b01} in cycle N.
  - Response: perform high only in N+2 with op=100, k=01; res_valid in N+4 (SETTLE_CYCLES=1); res_data=7.
- Copy select:
  - Stimulus: push {3'b011, 2'b10} with alu_r2=5'd9.
  - Response: res_data=9, not alu_r0.
- FIFO full/backpressure:
  - Stimulus: hold res_ready=0; push 5 commands with FIFO_DEPTH=4.
  - Response: the first is in flight; 4 are queued; cmd_ready=0 on the 6th offer. Releasing res_ready drains them in order, with 5 results in push order and exactly 5 perform pulses.
- Result hold:
  - Stimulus: res_ready=0 for 10 cycles in DONE.
  - Response: res_valid and res_data stable; op/k unchanged; no further perform.
- Reset mid-operation:
  - Stimulus: assert rst during WAIT with 2 commands queued.
  - Response: next cycle all outputs at reset values, FIFO empty, busy=0; no result is ever emitted for those commands.
- SETTLE_CYCLES=3 with CALC_ISSUE_COUNT_EN defined:
  - Response: res_valid at N+6; issue_count increments once per command; wraps to 0 after 256 commands.
